// File: rtl/sys_arr_skew_feeder_if.sv
// Feeder-side bus of the systolic array: job control, input vector stream, skewed array output.
// vec_in is transferred on each rising edge where vec_valid and vec_ready are both high; the feeder
// never stalls its output, and vec_ready depends only on feeder state, never on vec_valid.
interface sys_arr_skew_feeder_if #(
  parameter int width_height = 2,
  parameter int cnt_width    = 8
);
  logic                      start;
  logic [cnt_width-1:0]      num_vecs;
  logic                      busy;
  logic                      done;
  logic [8*width_height-1:0] vec_in;
  logic                      vec_valid;
  logic                      vec_ready;
  logic [8*width_height-1:0] datain;
  logic                      active;

  modport master (
    output start, num_vecs, vec_in, vec_valid,
    input  busy, done, vec_ready, datain, active
  );

  modport slave (
    input  start, num_vecs, vec_in, vec_valid,
    output busy, done, vec_ready, datain, active
  );
endinterface

// File: rtl/sys_arr_skew_feeder.sv
// Feeds a job of input vectors into the systolic array, skewing row i by i cycles,
// then drains the skew pipeline and pulses done.
module sys_arr_skew_feeder #(
  parameter int width_height = 2,
  parameter int cnt_width    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sys_arr_skew_feeder_if.slave bus,
  output logic [1:0]           dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [cnt_width-1:0] DRAIN_INIT = cnt_width'(width_height - 1);
  localparam logic [cnt_width-1:0] ONE        = cnt_width'(1);

  state_e               state_q, state_d;
  logic [cnt_width-1:0] num_q, num_d;
  logic [cnt_width-1:0] acc_q, acc_d;
  logic [cnt_width-1:0] drain_q, drain_d;
  logic                 active_q;
  logic                 accept;
  logic [8*width_height-1:0] datain_w;

  assign accept = bus.vec_valid && (state_q == S_FEED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      num_q    <= '0;
      acc_q    <= '0;
      drain_q  <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      acc_q    <= acc_d;
      drain_q  <= drain_d;
      active_q <= accept;
    end
  end

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    acc_d   = acc_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.num_vecs != '0) begin
            num_d   = bus.num_vecs;
            acc_d   = '0;
            state_d = S_FEED;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_FEED: begin
        if (accept) begin
          acc_d = acc_q + ONE;
          if (acc_q + ONE == num_q) begin
            // A one-row array has no skew to drain.
            if (width_height > 1) begin
              state_d = S_DRAIN;
              drain_d = DRAIN_INIT;
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end
      S_DRAIN: begin
        drain_d = drain_q - ONE;
        if (drain_q == ONE) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Lane i is an (i+1)-byte shift register; the newest byte enters at the bottom.
  for (genvar i = 0; i < width_height; i++) begin : g_lane
    localparam int LW = 8 * (i + 1);
    logic [LW-1:0] pipe_q;
    logic [7:0]    lane_in;

    assign lane_in = accept ? bus.vec_in[8*i +: 8] : 8'h00;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pipe_q <= '0;
      else        pipe_q <= (pipe_q << 8) | LW'(lane_in);
    end

    assign datain_w[8*i +: 8] = pipe_q[8*i +: 8];
  end

  assign bus.datain    = datain_w;
  assign bus.active    = active_q;
  assign bus.vec_ready = (state_q == S_FEED);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign dbg_state_o   = state_q;

endmodule

// File: doc/sys_arr_skew_feeder.md
Name: sys_arr_skew_feeder

Overview:
- Upstream stage of the systolic array.
- Accepts one full input vector (one byte per array row) per cycle from the unified buffer over a valid/ready handshake.
- Skews the vector diagonally so row i receives its byte i cycles after row 0, then drives the array's datain bus and top-left active bit.
- Sequences a job of num_vecs vectors: feeds them, drains the skew pipeline, signals done.

Parameters:
- width_height, 2, array rows/columns; equals the array's width_height.
- cnt_width, 8, width of the vector-count field and internal counters.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  pulse; begins a job when sampled in IDLE.
- num_vecs  input  cnt_width  vectors in the job; latched when start is accepted.
- busy  output  1  high in FEED, DRAIN and DONE.
- done  output  1  one-cycle pulse at job end.
- vec_in  input  8*width_height  input vector; row 0 byte in LSBs.
- vec_valid  input  1  vec_in valid.
- vec_ready  output  1  high only in FEED; decoded from state, no combinational path from vec_valid.
- datain  output  8*width_height  skewed data to array; row 0 in LSBs.
- active  output  1  array active bit, aligned with row 0 data.

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE.
  - Counters and all skew registers clear to 0.
  - Outputs: datain=0, active=0, done=0, busy=0, vec_ready=0.
  - Reset mid-job abandons the job; no done pulse is produced.
- States: IDLE, FEED, DRAIN, DONE.
- IDLE:
  - start=1 and num_vecs!=0: latch num_vecs, clear accept counter, go to FEED.
  - start=1 and num_vecs=0: go to DONE directly.
- Start outside IDLE is ignored.
- FEED:
  - Accept occurs when vec_valid & vec_ready; the accept counter increments.
  - On the accept that makes the count equal the latched num_vecs:
    - width_height>1: go to DRAIN with drain counter = width_height-1.
    - width_height=1: go to DONE.
- DRAIN: the drain counter decrements each cycle; on the cycle it reaches 1, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Skew pipeline:
  - Lane i has i+1 register stages; lane 0 is a single output register.
  - Each cycle, the lane-i input is byte i of vec_in on an accept; otherwise 0 (bubble).
  - Vector accepted at edge t: lane i byte appears on datain in the cycle after edge t+i.
- The pipeline never stalls.
  - A FEED cycle without vec_valid inserts a zero bubble and active=0 for that slot.
  - DRAIN and IDLE keep shifting zeros.
- active: a registered copy of the accept strobe, so it is high in the cycle after each accept edge.
- Latency, last accept at edge t:
  - Last lane-(width_height-1) byte is visible after edge t+width_height-1.
  - done is high in the cycle after edge t+width_height-1 and returns low one cycle later.
- No arithmetic on data; bytes pass through unmodified.
- Counter overflow is impossible, since num_vecs is limited to 2^cnt_width-1.

Test Plan:
- Reset: hold rst_n=0 with clk running, drive vec_valid=1 and start=1 -> datain=0, active=0, busy=0, vec_ready=0. Release -> IDLE, vec_ready=0.
- Basic skew (width_height=4): start with num_vecs=2; vectors 0x04030201 and 0x08070605 with valid held high, accepts at edges t and t+1.
  - After edge t: datain lane0=0x01, others 0.
  - After edge t+1: lane0=0x05, lane1=0x02.
  - After edge t+2: lane1=0x06, lane2=0x03.
  - After edge t+3: lane2=0x07, lane3=0x04.
  - After edge t+4: lane3=0x08; done=1 in that cycle.
  - active=1 only in the cycles after edges t and t+1.
- Bubbles: num_vecs=3 with vec_valid low for one cycle between the 1st and 2nd vectors -> one all-zero diagonal with active=0 in that slot; exactly 3 accepts occur, then done.
- Zero-length job: start with num_vecs=0 -> done=1 one cycle after start; vec_ready never rises; datain stays 0.
- Start while busy: assert start mid-FEED with num_vecs=5 -> ignored; the job keeps the originally latched count and produces exactly one done.
- Reset mid-operation: pull rst_n low during DRAIN -> all outputs 0 immediately (async); no done pulse; a new start after release runs normally.
